// File: rtl/ama_riscv_pkg.sv
// Shared types for the unified-memory arbiter: owner tags for in-flight reads
// and the one-hot-free grant selector used inside the arbiter.
package ama_riscv_pkg;

  typedef enum logic {
    OWN_IFU = 1'b0,
    OWN_LSU = 1'b1
  } arb_owner_t;

  typedef enum logic [1:0] {
    GNT_NONE = 2'd0,
    GNT_IFU  = 2'd1,
    GNT_LSU  = 2'd2
  } arb_grant_t;

endpackage

// File: rtl/ama_riscv_fifo.sv
// Small synchronous FIFO with occupancy counter; used as the in-order owner
// queue that steers each read response back to its requester.
module ama_riscv_fifo #(
  parameter int WIDTH = 1,
  parameter int DEPTH = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] head,
  output logic             full,
  output logic             empty
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             do_push, do_pop;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  assign full    = (count_q == CNT_W'(DEPTH));
  assign empty   = (count_q == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign head    = mem_q[rd_ptr_q];

  // NOTE: every signal assigned in always_comb gets a default first, so no path leaves it unassigned and no latch is inferred.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push) wr_ptr_d = ptr_inc(wr_ptr_q);
    if (do_pop)  rd_ptr_d = ptr_inc(rd_ptr_q);
    if (do_push && !do_pop)      count_d = count_q + CNT_W'(1);
    else if (do_pop && !do_push) count_d = count_q - CNT_W'(1);
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together from pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // NOTE: storage is deliberately not reset; the pointers and count define validity, which keeps this a plain RAM.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= push_data;
  end

endmodule

// File: rtl/ama_riscv_mem_arbiter.sv
// Arbitrates IFU fetches and LSU loads/stores onto one shared memory port;
// read responses return in order and are steered by the owner FIFO.
module ama_riscv_mem_arbiter
  import ama_riscv_pkg::*;
#(
  parameter int ADDR_W          = 32,
  parameter int MAX_OUTSTANDING = 2,
  parameter int STARVE_LIMIT    = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              ifu_req_valid,
  output logic              ifu_req_ready,
  input  logic [ADDR_W-1:0] ifu_req_addr,
  output logic              ifu_rsp_valid,
  output logic [31:0]       ifu_rsp_data,
  input  logic              lsu_req_valid,
  output logic              lsu_req_ready,
  input  logic [ADDR_W-1:0] lsu_req_addr,
  input  logic              lsu_req_we,
  input  logic [31:0]       lsu_req_wdata,
  input  logic [3:0]        lsu_req_wmask,
  output logic              lsu_rsp_valid,
  output logic [31:0]       lsu_rsp_data,
  output logic              mem_req_valid,
  input  logic              mem_req_ready,
  output logic [ADDR_W-1:0] mem_req_addr,
  output logic              mem_req_we,
  output logic [31:0]       mem_req_wdata,
  output logic [3:0]        mem_req_wmask,
  input  logic              mem_rsp_valid,
  input  logic [31:0]       mem_rsp_data,
  output logic              err_orphan_rsp
);

  localparam int STARVE_W = $clog2(STARVE_LIMIT + 1);

  logic [STARVE_W-1:0] starve_cnt_q, starve_cnt_d;
  logic                err_orphan_q, err_orphan_d;

  logic       fifo_full, fifo_empty;
  logic [0:0] head_bits, push_bits;
  arb_owner_t head_owner, push_owner;
  arb_grant_t grant;
  logic       ifu_ok, lsu_ok, ifu_first;
  logic       mem_fire, read_push, rsp_pop;

  // Full is registered state, so ready never depends on mem_rsp_* in the same cycle.
  always_comb begin
    ifu_ok    = ifu_req_valid && !fifo_full;
    lsu_ok    = lsu_req_valid && (lsu_req_we || !fifo_full);
    ifu_first = (starve_cnt_q == STARVE_W'(STARVE_LIMIT)) || !lsu_req_valid;
    grant     = GNT_NONE;
    if (!rst) begin
      if (ifu_first) begin
        if (ifu_ok)      grant = GNT_IFU;
        else if (lsu_ok) grant = GNT_LSU;
      end else begin
        if (lsu_ok)      grant = GNT_LSU;
        else if (ifu_ok) grant = GNT_IFU;
      end
    end
  end

  always_comb begin
    mem_req_addr  = '0;
    mem_req_we    = 1'b0;
    mem_req_wdata = '0;
    mem_req_wmask = '0;
    case (grant)
      GNT_IFU: mem_req_addr = ifu_req_addr;
      GNT_LSU: begin
        mem_req_addr  = lsu_req_addr;
        mem_req_we    = lsu_req_we;
        mem_req_wdata = lsu_req_wdata;
        mem_req_wmask = lsu_req_wmask;
      end
      default: ;
    endcase
  end

  assign mem_req_valid = (grant != GNT_NONE);
  assign mem_fire      = mem_req_valid && mem_req_ready;
  assign ifu_req_ready = mem_fire && (grant == GNT_IFU);
  assign lsu_req_ready = mem_fire && (grant == GNT_LSU);

  assign read_push  = ifu_req_ready || (lsu_req_ready && !lsu_req_we);
  assign push_owner = ifu_req_ready ? OWN_IFU : OWN_LSU;
  assign push_bits  = push_owner;
  assign rsp_pop    = mem_rsp_valid && !fifo_empty;
  assign head_owner = arb_owner_t'(head_bits);

  ama_riscv_fifo #(
    .WIDTH (1),
    .DEPTH (MAX_OUTSTANDING)
  ) u_owner_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (read_push),
    .push_data (push_bits),
    .pop       (rsp_pop),
    .head      (head_bits),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  assign ifu_rsp_valid  = !rst && rsp_pop && (head_owner == OWN_IFU);
  assign lsu_rsp_valid  = !rst && rsp_pop && (head_owner == OWN_LSU);
  assign ifu_rsp_data   = mem_rsp_data;
  assign lsu_rsp_data   = mem_rsp_data;
  assign err_orphan_rsp = err_orphan_q;

  // The counter only tracks LSU wins while a fetch is actually waiting.
  always_comb begin
    starve_cnt_d = starve_cnt_q;
    if (!ifu_req_valid || ifu_req_ready) begin
      starve_cnt_d = '0;
    end else if (lsu_req_ready && (starve_cnt_q != STARVE_W'(STARVE_LIMIT))) begin
      starve_cnt_d = starve_cnt_q + STARVE_W'(1);
    end
    err_orphan_d = err_orphan_q || (mem_rsp_valid && fifo_empty);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      starve_cnt_q <= '0;
      err_orphan_q <= 1'b0;
    end else begin
      starve_cnt_q <= starve_cnt_d;
      err_orphan_q <= err_orphan_d;
    end
  end

endmodule

// File: doc/ama_riscv_mem_arbiter.md
# ama_riscv_mem_arbiter

Arbitrates the core's instruction-fetch (IFU) and load/store (LSU) requests onto one shared single-port memory interface, so that a unified instruction/data memory can replace separate imem/dmem. It sits between `ama_riscv_core` and the unified memory inside `ama_riscv_core_top`. Reads return in order, and an in-order owner FIFO routes each read response back to its requester. A starvation counter guarantees fetch progress under sustained LSU traffic.

## Interface
Parameters:
- `ADDR_W`, default 32: byte address width.
- `MAX_OUTSTANDING`, default 2: maximum number of in-flight reads (owner FIFO depth, at least 1).
- `STARVE_LIMIT`, default 4: maximum consecutive LSU grants while IFU waits (at least 1).

Ports:
- `clk` in 1: clock. Single clock domain.
- `rst` in 1: synchronous, active-high reset.
- `ifu_req_valid` in 1: fetch request.
- `ifu_req_ready` out 1: fetch request accepted this cycle.
- `ifu_req_addr` in ADDR_W: fetch byte address, word aligned.
- `ifu_rsp_valid` out 1: fetch data valid.
- `ifu_rsp_data` out 32: fetch data.
- `lsu_req_valid` in 1: load/store request.
- `lsu_req_ready` out 1: load/store request accepted.
- `lsu_req_addr` in ADDR_W: load/store byte address.
- `lsu_req_we` in 1: 1 = store.
- `lsu_req_wdata` in 32: store data.
- `lsu_req_wmask` in 4: store byte enables.
- `lsu_rsp_valid` out 1: load data valid.
- `lsu_rsp_data` out 32: load data.
- `mem_req_valid` out 1: request to memory.
- `mem_req_ready` in 1: memory accepts the request.
- `mem_req_addr` out ADDR_W: address to memory.
- `mem_req_we` out 1: write enable to memory.
- `mem_req_wdata` out 32: write data to memory.
- `mem_req_wmask` out 4: byte enables to memory.
- `mem_rsp_valid` in 1: memory read data valid. Memory returns read data in order, with latency of 1 or more cycles. Stores get no response.
- `mem_rsp_data` in 32: memory read data.
- `err_orphan_rsp` out 1: sticky flag; set when `mem_rsp_valid` arrives while no read is outstanding.

## Operation
- **Grant selection** is combinational each cycle:
  - The LSU has priority by default.
  - The IFU wins when `starve_cnt == STARVE_LIMIT`, or when `lsu_req_valid` is 0.
- **Read eligibility:** a read (IFU, or LSU with `we=0`) is eligible only if the owner FIFO is not full. A pop in the same cycle does NOT free a slot for a push.
- **Stores** need no FIFO slot.
- **Ineligible winner:** if the priority winner is ineligible (a read while the FIFO is full), the other requester is granted if it is eligible. A store therefore bypasses a full FIFO.
- **Memory request:** `mem_req_valid` is asserted whenever a granted requester exists. The mem_req payload muxes from the winner. For IFU requests, `we=0`, `wmask=0`, `wdata=0`.
- **Acceptance:** the handshake completes when `mem_req_valid && mem_req_ready`. Only the granted requester sees `*_req_ready=1`, and only in that cycle.
- **Owner push:** on an accepted read, the owner tag (`OWN_IFU` or `OWN_LSU`) is pushed into the FIFO.
- **Response routing:** on `mem_rsp_valid`, the FIFO head is popped and the data is routed combinationally:
  - `ifu_rsp_valid = mem_rsp_valid && head == OWN_IFU`, and similarly for the LSU.
  - Both `*_rsp_data` outputs always carry `mem_rsp_data`.
  - Requesters cannot backpressure responses.
- **Orphan responses:** `mem_rsp_valid` with an empty FIFO is dropped, and `err_orphan_rsp` is set to 1 from the next cycle. It clears only on `rst`.
- **`starve_cnt`** has width `$clog2(STARVE_LIMIT+1)`:
  - Increment (saturating at `STARVE_LIMIT`) on an accepted LSU request while `ifu_req_valid` is high.
  - Clear on an accepted IFU request, or in any cycle where `ifu_req_valid` is low.
- **Simultaneous accept and response:** an accepted request and a response in the same cycle perform both a push and a pop. Occupancy is unchanged.

## Timing
- Zero-cycle arbitration: ready depends combinationally on valid and `mem_req_ready`. There are no combinational paths from `mem_rsp_*` to `*_req_ready`.
- Response path latency is 0 cycles (pass-through).
- Reset values:
  - FIFO empty, `starve_cnt=0`, `err_orphan_rsp=0`.
  - While `rst` is high, all `*_ready`, `*_valid` and `mem_req_valid` outputs are forced to 0.
- Reset mid-operation:
  - Outstanding reads are discarded.
  - Memory responses returning after reset deassertion hit an empty FIFO, are dropped and set `err_orphan_rsp`. The top level resets memory with the same `rst` to avoid this.

## Structure
- `ama_riscv_pkg` holds `typedef enum logic {OWN_IFU, OWN_LSU} arb_owner_t`.
- The owner FIFO is a sub-module, `ama_riscv_fifo`, parameterized on width and depth. It has `push`, `pop`, `full` and `empty`, with pointer wrap-around at the depth. The arbiter owns the grant logic and `starve_cnt`.

## Test plan
- **Solo fetch:** IFU read at 0x100, memory latency 2 → `ifu_rsp_valid` two cycles after accept; FIFO empty afterwards; `lsu_rsp_valid` stays 0.
- **Contention:** IFU and LSU both valid every cycle, `STARVE_LIMIT=4` → grant order LSU ×4, IFU, LSU ×4, IFU…; IFU never waits more than 4 accepts.
- **Backpressure/full:** `MAX_OUTSTANDING=2`, two LSU reads accepted with no response, then IFU read → blocked. An LSU store in the same window → accepted. The first response frees the slot one cycle later.
- **Interleaved ordering:** IFU read A, then LSU read B, responses 0xAAAA and 0xBBBB → 0xAAAA on the IFU path only, then 0xBBBB on the LSU path only.
- **Orphan and reset:** assert `rst` with 1 read outstanding, then drive `mem_rsp_valid` after release → no `*_rsp_valid`; `err_orphan_rsp=1` next cycle; cleared by the next `rst`.
